pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_perf_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the FSM encodings, the latency default and the load-use hazard check.
package pipeline_hazard_ctrl_pkg;

  typedef logic [4:0] reg_label_t;

  localparam int unsigned LONG_LATENCY_DEFAULT = 32;
  localparam int unsigned LAT_CNT_W            = 6;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LONG_WAIT = 2'd1;
  localparam logic [1:0] ST_LONG_DONE = 2'd2;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic f_load_use(input logic       is_load,
                                      input logic       wb_en,
                                      input reg_label_t rd,
                                      input reg_label_t rs1,
                                      input reg_label_t rs2);
    return is_load & wb_en & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller.
// The master modport is the pipeline side; the slave modport is the controller.
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  reg_label_t  rs1_label_if_id_i;
  reg_label_t  rs2_label_if_id_i;
  reg_label_t  rd_id_ex_i;
  logic        reg_wb_en_id_ex_i;
  logic        is_load_instruction_id_ex_i;
  logic        is_long_id_ex_i;
  logic        branch_taken_ex_i;
  logic        imem_busywait_i;
  logic        dmem_busywait_i;

  logic        busywait_o;
  logic        stall_if_id_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic [1:0]  hazard_state_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  modport master (
    output rs1_label_if_id_i, rs2_label_if_id_i, rd_id_ex_i, reg_wb_en_id_ex_i,
           is_load_instruction_id_ex_i, is_long_id_ex_i, branch_taken_ex_i,
           imem_busywait_i, dmem_busywait_i,
    input  busywait_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o,
           hazard_state_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  rs1_label_if_id_i, rs2_label_if_id_i, rd_id_ex_i, reg_wb_en_id_ex_i,
           is_load_instruction_id_ex_i, is_long_id_ex_i, branch_taken_ex_i,
           imem_busywait_i, dmem_busywait_i,
    output busywait_o, stall_if_id_o, flush_if_id_o, flush_id_ex_o,
           hazard_state_o, stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running 32-bit event counter used for the hazard performance statistics.
// Counts one per enabled cycle and wraps silently from all-ones to zero.
module hazard_perf_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_count <= '0;
    end else if (en_i) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: long-op busywait FSM, load-use stall and branch flush
// generation, plus stall/flush performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LONG_LATENCY = LONG_LATENCY_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pipeline_hazard_ctrl_if.slave  bus
);

  // Detection cycle plus LONG_WAIT cycles from LAT_LOAD down to 0 add up to LONG_LATENCY.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LONG_LATENCY - 2);

  logic [1:0]           r_state;
  logic [LAT_CNT_W-1:0] r_lat_cnt;

  logic        w_long_req;
  logic        w_busywait;
  logic        w_load_use;
  logic        w_stall;
  logic        w_flush_if;
  logic        w_stall_en;
  logic [31:0] w_stall_cycles;
  logic [31:0] w_flush_count;

  // Gating with reset keeps busywait driven by the memories alone while reset is held.
  assign w_long_req = bus.is_long_id_ex_i & (r_state == ST_IDLE) & rst_i;
  assign w_busywait = bus.imem_busywait_i | bus.dmem_busywait_i | w_long_req |
                      (r_state == ST_LONG_WAIT);
  assign w_load_use = f_load_use(bus.is_load_instruction_id_ex_i, bus.reg_wb_en_id_ex_i,
                                 bus.rd_id_ex_i, bus.rs1_label_if_id_i,
                                 bus.rs2_label_if_id_i);
  assign w_stall    = w_load_use & ~w_busywait & ~bus.branch_taken_ex_i;
  assign w_flush_if = bus.branch_taken_ex_i & ~w_busywait;
  assign w_stall_en = w_busywait | w_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.is_long_id_ex_i) begin
            r_state   <= ST_LONG_WAIT;
            r_lat_cnt <= LAT_LOAD;
          end
        end
        ST_LONG_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state <= ST_LONG_DONE;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end
        // Stay here until ID/EX advances so the same long op cannot retrigger.
        ST_LONG_DONE: begin
          if (!w_busywait) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  hazard_perf_counter u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (w_stall_en),
    .count_o (w_stall_cycles)
  );

  hazard_perf_counter u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (w_flush_if),
    .count_o (w_flush_count)
  );

  assign bus.busywait_o     = w_busywait;
  assign bus.stall_if_id_o  = w_stall;
  assign bus.flush_if_id_o  = w_flush_if;
  assign bus.flush_id_ex_o  = w_flush_if | w_stall;
  assign bus.hazard_state_o = r_state;
  assign bus.stall_cycles_o = w_stall_cycles;
  assign bus.flush_count_o  = w_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a behavioural model pushes the
// expected outputs of every driven cycle; a monitor pops and compares them.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  localparam int unsigned LAT = 32;

  typedef struct {
    logic        busy;
    logic        stall;
    logic        flushIf;
    logic        flushEx;
    logic [1:0]  state;
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
  } expect_t;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.LONG_LATENCY(LAT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (hif)
  );

  expect_t     sbQueue[$];
  expect_t     monE;
  int          assertCount    = 0;
  int          failCount      = 0;
  int          busyHighCycles = 0;
  int          mState         = 0;
  int          mLeft          = 0;
  logic [31:0] mStallCnt      = '0;
  logic [31:0] mFlushCnt      = '0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge, pushes the expected outputs
  // for that cycle and advances the model across the following rising edge.
  task automatic applyStimulus(input logic rst, input logic imem, input logic dmem,
                               input logic isLong, input logic isLoad, input logic wbEn,
                               input logic br, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    expect_t e;
    logic    longReq;
    logic    busy;
    logic    loadUse;
    logic    stall;
    logic    flushIf;
    @(negedge clk_i);
    rst_i                           = rst;
    hif.imem_busywait_i             = imem;
    hif.dmem_busywait_i             = dmem;
    hif.is_long_id_ex_i             = isLong;
    hif.is_load_instruction_id_ex_i = isLoad;
    hif.reg_wb_en_id_ex_i           = wbEn;
    hif.branch_taken_ex_i           = br;
    hif.rd_id_ex_i                  = rd;
    hif.rs1_label_if_id_i           = rs1;
    hif.rs2_label_if_id_i           = rs2;
    if (!rst) begin
      mState    = 0;
      mLeft     = 0;
      mStallCnt = '0;
      mFlushCnt = '0;
    end
    longReq   = isLong && (mState == 0) && rst;
    busy      = imem || dmem || longReq || (mState == 1);
    loadUse   = isLoad && wbEn && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
    stall     = loadUse && !busy && !br;
    flushIf   = br && !busy;
    e.busy     = busy;
    e.stall    = stall;
    e.flushIf  = flushIf;
    e.flushEx  = flushIf || stall;
    e.state    = 2'(mState);
    e.stallCnt = mStallCnt;
    e.flushCnt = mFlushCnt;
    sbQueue.push_back(e);
    if (rst) begin
      if (busy || stall) mStallCnt = mStallCnt + 32'd1;
      if (flushIf)       mFlushCnt = mFlushCnt + 32'd1;
      case (mState)
        0: if (isLong) begin
             mState = 1;
             mLeft  = LAT - 1;
           end
        1: begin
             mLeft = mLeft - 1;
             if (mLeft == 0) mState = 2;
           end
        default: if (!busy) mState = 0;
      endcase
    end
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Outputs are sampled mid-cycle, well clear of the rising edge.
  always @(negedge clk_i) begin
    #3;
    if (sbQueue.size() > 0) begin
      monE = sbQueue.pop_front();
      checkOutput("busywait_o",     32'(hif.busywait_o),     32'(monE.busy));
      checkOutput("stall_if_id_o",  32'(hif.stall_if_id_o),  32'(monE.stall));
      checkOutput("flush_if_id_o",  32'(hif.flush_if_id_o),  32'(monE.flushIf));
      checkOutput("flush_id_ex_o",  32'(hif.flush_id_ex_o),  32'(monE.flushEx));
      checkOutput("hazard_state_o", 32'(hif.hazard_state_o), 32'(monE.state));
      checkOutput("stall_cycles_o", hif.stall_cycles_o,      monE.stallCnt);
      checkOutput("flush_count_o",  hif.flush_count_o,       monE.flushCnt);
      if (hif.busywait_o) busyHighCycles++;
    end
  end

  initial begin
    rst_i                           = 1'b0;
    hif.imem_busywait_i             = 1'b0;
    hif.dmem_busywait_i             = 1'b0;
    hif.is_long_id_ex_i             = 1'b0;
    hif.is_load_instruction_id_ex_i = 1'b0;
    hif.reg_wb_en_id_ex_i           = 1'b0;
    hif.branch_taken_ex_i           = 1'b0;
    hif.rd_id_ex_i                  = 5'd0;
    hif.rs1_label_if_id_i           = 5'd0;
    hif.rs2_label_if_id_i           = 5'd0;

    $display("[TB] reset behaviour");
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyIdle(2);

    $display("[TB] long operation");
    #4;
    busyHighCycles = 0;
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyIdle(1);
    #4;
    checkOutput("long_busy_cycles", 32'(busyHighCycles), 32'd32);
    checkOutput("long_stall_count", hif.stall_cycles_o, 32'd32);

    $display("[TB] load-use hazards");
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 5'd5, 5'd1, 5'd5);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 5'd5, 5'd1, 5'd5);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 5'd7, 5'd7, 5'd2);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 5'd9, 5'd9, 5'd3);
    applyStimulus(1, 0, 1, 0, 1, 1, 0, 5'd9, 5'd9, 5'd3);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 5'd31, 5'd30, 5'd31);

    $display("[TB] branch deferred by dmem busywait");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    applyIdle(1);
    #4;
    checkOutput("branch_flush_count", hif.flush_count_o, 32'd1);

    $display("[TB] branch and load-use together");
    applyStimulus(1, 0, 0, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0);
    applyIdle(1);

    $display("[TB] reset during LONG_WAIT");
    for (int i = 0; i < 11; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #4;
    checkOutput("reset_state", 32'(hif.hazard_state_o), 32'd0);
    checkOutput("reset_stall_count", hif.stall_cycles_o, 32'd0);
    busyHighCycles = 0;
    for (int i = 0; i < LAT + 1; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyIdle(1);
    #4;
    checkOutput("restart_busy_cycles", 32'(busyHighCycles), 32'd32);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1,
                    1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)));
    end
    applyIdle(LAT + 4);

    $display("[TB] stall counter wrap");
    @(negedge clk_i);
    force dut.u_stall_cnt.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.r_count;
    mStallCnt = 32'hFFFF_FFFE;
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    applyIdle(1);
    #4;
    checkOutput("stall_wrap", hif.stall_cycles_o, 32'd0);

    applyIdle(2);
    #4;
    checkOutput("scoreboard_drained", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
